// File: rtl/frame_stream_arbiter_if.sv
// Purpose: AXI-Stream bundle between NUM_INPUTS producers, the frame arbiter
//          and the single downstream consumer.
// Ports (signals):
//   dataIn/dataInTStrb/dataInTValid/dataInTLast  packed per-requester stream inputs
//   dataInTReady                                 per-requester ready back to producers
//   dataOut/dataOutTStrb/dataOutTValid/dataOutTLast  granted stream towards the buffer
//   dataOutTReady                                downstream ready
// Modports: master = arbiter side, slave = producer/consumer side.
interface frame_stream_arbiter_if #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_INPUTS*DATA_WIDTH-1:0] dataIn;
    logic [NUM_INPUTS*STRB_WIDTH-1:0] dataInTStrb;
    logic [NUM_INPUTS-1:0]            dataInTValid;
    logic [NUM_INPUTS-1:0]            dataInTLast;
    logic [NUM_INPUTS-1:0]            dataInTReady;
    logic [DATA_WIDTH-1:0]            dataOut;
    logic [STRB_WIDTH-1:0]            dataOutTStrb;
    logic                             dataOutTValid;
    logic                             dataOutTLast;
    logic                             dataOutTReady;

    modport master (
        input  dataIn, dataInTStrb, dataInTValid, dataInTLast, dataOutTReady,
        output dataInTReady, dataOut, dataOutTStrb, dataOutTValid, dataOutTLast
    );

    modport slave (
        output dataIn, dataInTStrb, dataInTValid, dataInTLast, dataOutTReady,
        input  dataInTReady, dataOut, dataOutTStrb, dataOutTValid, dataOutTLast
    );
endinterface

// File: rtl/frame_stream_arbiter.sv
// Purpose: frame-granular round-robin arbiter sharing one AXI-Stream output
//          between NUM_INPUTS producers, with max-frame-length truncation.
// Ports:
//   dataClock, dataReset  clock and synchronous active-high reset
//   bus                   stream bundle (master modport)
//   configEnable          1 = new grants allowed; 0 = finish current frame then stop
//   arbiterStatus         [31:30] state, [29:27] grant, [26] truncSticky, [25:0] beat count
//   framesForwarded       frames completed on the output (wraps)
//   framesTruncated       frames cut at MAX_FRAME_WORDS (wraps)
module frame_stream_arbiter #(
    parameter int unsigned NUM_INPUTS      = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_FRAME_WORDS = 1024
) (
    input  logic                          dataClock,
    input  logic                          dataReset,
    frame_stream_arbiter_if.master        bus,
    input  logic                          configEnable,
    output logic [31:0]                   arbiterStatus,
    output logic [31:0]                   framesForwarded,
    output logic [31:0]                   framesTruncated
);
    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned GRANT_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    // Wide enough to hold MAX_FRAME_WORDS itself after a truncating beat.
    localparam int unsigned BEAT_WIDTH  = $clog2(MAX_FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                  state, stateNext;
    logic [GRANT_WIDTH-1:0]  grant, grantNext;
    logic [GRANT_WIDTH-1:0]  rrPointer, rrPointerNext;
    logic [BEAT_WIDTH-1:0]   beatCount, beatCountNext;
    logic                    truncSticky, truncStickyNext;
    logic [31:0]             framesForwardedNext, framesTruncatedNext;

    logic [DATA_WIDTH-1:0]   selData;
    logic [STRB_WIDTH-1:0]   selStrb;
    logic                    selValid, selLast;
    logic [NUM_INPUTS-1:0]   grantOneHot;
    logic [GRANT_WIDTH-1:0]  pick;
    logic                    pickValid;
    logic                    atLastBeat;

    // Select the granted requester's stream.
    always_comb begin
        selData     = '0;
        selStrb     = '0;
        selValid    = 1'b0;
        selLast     = 1'b0;
        grantOneHot = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == GRANT_WIDTH'(i)) begin
                selData        = bus.dataIn[i*DATA_WIDTH +: DATA_WIDTH];
                selStrb        = bus.dataInTStrb[i*STRB_WIDTH +: STRB_WIDTH];
                selValid       = bus.dataInTValid[i];
                selLast        = bus.dataInTLast[i];
                grantOneHot[i] = 1'b1;
            end
        end
    end

    // Round-robin pick: lowest valid index above rrPointer, else lowest at or below it.
    always_comb begin
        logic                   hiFound, loFound;
        logic [GRANT_WIDTH-1:0] hiIdx, loIdx;
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (bus.dataInTValid[i]) begin
                if (GRANT_WIDTH'(i) > rrPointer) begin
                    if (!hiFound) begin
                        hiFound = 1'b1;
                        hiIdx   = GRANT_WIDTH'(i);
                    end
                end else if (!loFound) begin
                    loFound = 1'b1;
                    loIdx   = GRANT_WIDTH'(i);
                end
            end
        end
        pickValid = hiFound | loFound;
        pick      = hiFound ? hiIdx : loIdx;
    end

    assign atLastBeat = (beatCount == BEAT_WIDTH'(MAX_FRAME_WORDS - 1));

    // Next-state and stream outputs.
    always_comb begin
        stateNext           = state;
        grantNext           = grant;
        rrPointerNext       = rrPointer;
        beatCountNext       = beatCount;
        truncStickyNext     = truncSticky;
        framesForwardedNext = framesForwarded;
        framesTruncatedNext = framesTruncated;
        bus.dataOut         = '0;
        bus.dataOutTStrb    = '0;
        bus.dataOutTValid   = 1'b0;
        bus.dataOutTLast    = 1'b0;
        bus.dataInTReady    = '0;

        case (state)
            IDLE: begin
                if (configEnable && pickValid) begin
                    grantNext = pick;
                    stateNext = STREAM;
                end
            end
            STREAM: begin
                bus.dataOut       = selData;
                bus.dataOutTStrb  = selStrb;
                bus.dataOutTValid = selValid;
                bus.dataOutTLast  = selLast | atLastBeat;
                bus.dataInTReady  = grantOneHot & {NUM_INPUTS{bus.dataOutTReady}};
                if (selValid && bus.dataOutTReady) begin
                    // A genuine TLAST on the final legal beat wins over truncation.
                    if (selLast) begin
                        framesForwardedNext = framesForwarded + 32'd1;
                        rrPointerNext       = grant;
                        beatCountNext       = '0;
                        stateNext           = IDLE;
                    end else if (atLastBeat) begin
                        framesForwardedNext = framesForwarded + 32'd1;
                        framesTruncatedNext = framesTruncated + 32'd1;
                        truncStickyNext     = 1'b1;
                        beatCountNext       = beatCount + BEAT_WIDTH'(1);
                        stateNext           = DRAIN;
                    end else begin
                        beatCountNext       = beatCount + BEAT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // Swallow the tail of an over-length frame.
                bus.dataInTReady = grantOneHot;
                if (selValid && selLast) begin
                    rrPointerNext = grant;
                    beatCountNext = '0;
                    stateNext     = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge dataClock) begin
        if (dataReset) begin
            state           <= IDLE;
            grant           <= '0;
            rrPointer       <= GRANT_WIDTH'(NUM_INPUTS - 1);
            beatCount       <= '0;
            truncSticky     <= 1'b0;
            framesForwarded <= '0;
            framesTruncated <= '0;
        end else begin
            state           <= stateNext;
            grant           <= grantNext;
            rrPointer       <= rrPointerNext;
            beatCount       <= beatCountNext;
            truncSticky     <= truncStickyNext;
            framesForwarded <= framesForwardedNext;
            framesTruncated <= framesTruncatedNext;
        end
    end

    assign arbiterStatus = {2'(state), 3'(grant), truncSticky, 26'(beatCount)};
endmodule
